// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy
// scoreboard and a clear sequencer that zeroes storage after every reset.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   raddr      NREAD read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata      NREAD registered read data words
//   rbusy      NREAD registered busy bits (next-state busy of raddr_i)
//   wen        NWRITE write enables
//   waddr      NWRITE write addresses
//   wdata      NWRITE write data words
//   bset       mark bset_addr busy
//   bset_addr  register to mark busy
//   init_done  high once the clear sequence has completed
//
// state | meaning
// CLEAR | zeroing rf[1..DEPTH-1], one entry per edge; traffic ignored
// RUN   | normal read/write/scoreboard operation
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
  output logic [NREAD*DATA_WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]             rbusy,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
  input  logic                         bset,
  input  logic [ADDR_WIDTH-1:0]        bset_addr,
  output logic                         init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       clr_idx_q, clr_idx_d;
  logic                        init_done_q, init_done_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [NREAD*DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NREAD-1:0]            rbusy_q, rbusy_d;
  logic [DATA_WIDTH-1:0]       rf [DEPTH];

  // Write-first read: ascending port loop so the highest-numbered matching
  // write port wins, matching the storage update order below.
  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] ra);
    logic [DATA_WIDTH-1:0] v;
    v = rf[ra];
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra))
        v = wdata[j*DATA_WIDTH +: DATA_WIDTH];
    end
    if (ra == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    rdata_d     = '0;
    rbusy_d     = '0;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        for (int j = 0; j < NWRITE; j++) begin
          if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0))
            busy_d[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        end
        // Applied after the clears: a newly issued producer supersedes a
        // completing one on the same register.
        if (bset && (bset_addr != '0))
          busy_d[bset_addr] = 1'b1;
        for (int i = 0; i < NREAD; i++) begin
          rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = read_value(raddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
          rbusy_d[i] = busy_d[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_idx_q   <= ADDR_WIDTH'(1);
      init_done_q <= 1'b0;
      busy_q      <= '0;
      rdata_q     <= '0;
      rbusy_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
      rbusy_q     <= rbusy_d;
    end
  end

  // Storage has no reset of its own; the sequencer zeroes it. rf[0] is never
  // written because reads of address 0 are forced to zero.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        rf[clr_idx_q] <= '0;
      end else begin
        for (int j = 0; j < NWRITE; j++) begin
          if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0))
            rf[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign rdata     = rdata_q;
  assign rbusy     = rbusy_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        bset;
  logic [4:0]  bset_addr;
  logic        init_done;

  always #5 clk = ~clk;

  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2), .NWRITE(2)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .bset(bset), .bset_addr(bset_addr),
    .init_done(init_done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] d0, d1;
    logic        b0, b1;
  } exp_t;

  typedef struct {
    string       name;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  ra0, ra1;
    logic [31:0] d0, d1;
    logic        b0, b1;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[13];

  function automatic logic [31:0] val(input int a);
    return 32'h1000_0000 | (32'(a) * 32'h0000_0101);
  endfunction

  task automatic set_in(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1, input logic bs,
                        input logic [4:0] ba, input logic [4:0] ra0, input logic [4:0] ra1);
    wen       = we;
    waddr     = {wa1, wa0};
    wdata     = {wd1, wd0};
    bset      = bs;
    bset_addr = ba;
    raddr     = {ra1, ra0};
  endtask

  task automatic idle_in();
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Pushes the expectation for the inputs currently driven, clocks one edge,
  // then pops and compares against the registered outputs.
  task automatic step(input string name, input logic [31:0] d0, input logic [31:0] d1,
                      input logic b0, input logic b1);
    exp_t e;
    e.name = name; e.d0 = d0; e.d1 = d1; e.b0 = b0; e.b1 = b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sbq.pop_front();
      if ({rdata, rbusy} !== {e.d1, e.d0, e.b1, e.b0}) begin
        bad++;
        $display("FAIL %s: got rdata=%h rbusy=%b expected rdata=%h rbusy=%b",
                 e.name, rdata, rbusy, {e.d1, e.d0}, {e.b1, e.b0});
      end
    end
  endtask

  // Reset for ncyc edges, then run the clear while writing r4 and setting
  // busy on r4; both must be ignored.
  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    idle_in();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      check("reset_state", {31'd0, init_done, rdata[31:0]} ^ {rdata[63:32], rbusy, 30'd0},
            64'd0);
    end
    rst_n = 1'b1;
    set_in(2'b01, 5'd4, 32'hAA, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd4);
    for (int e = 1; e <= 31; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("clear_edge%0d", e), {init_done, rbusy, rdata},
            {(e == 31), 2'b00, 64'd0});
    end
    idle_in();
    for (int a = 0; a < 32; a++) begin
      set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
      step($sformatf("sweep_r%0d", a), 32'd0, 32'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();

    vt[0]  = '{"wr_r5",      2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'd0,  1'b0, 5'd0, 5'd1,  5'd2,  32'd0,        32'd0,        1'b0, 1'b0};
    vt[1]  = '{"rd_r5",      2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[2]  = '{"collide_r7", 2'b11, 5'd7,  32'h11,       5'd7,  32'h22, 1'b0, 5'd0, 5'd0,  5'd7,  32'd0,        32'h22,       1'b0, 1'b0};
    vt[3]  = '{"rd_r7",      2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b0, 5'd0, 5'd7,  5'd7,  32'h22,       32'h22,       1'b0, 1'b0};
    vt[4]  = '{"wr_r0",      2'b01, 5'd0,  32'h55,       5'd0,  32'd0,  1'b0, 5'd0, 5'd0,  5'd0,  32'd0,        32'd0,        1'b0, 1'b0};
    vt[5]  = '{"rd_r0",      2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b0, 5'd0, 5'd0,  5'd5,  32'd0,        32'hDEADBEEF, 1'b0, 1'b0};
    vt[6]  = '{"bset_r9",    2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b1, 5'd9, 5'd9,  5'd1,  32'd0,        32'd0,        1'b1, 1'b0};
    vt[7]  = '{"rd_busy_r9", 2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b0, 5'd0, 5'd9,  5'd9,  32'd0,        32'd0,        1'b1, 1'b1};
    vt[8]  = '{"wr_clr_r9",  2'b10, 5'd0,  32'd0,        5'd9,  32'h99, 1'b0, 5'd0, 5'd9,  5'd9,  32'h99,       32'h99,       1'b0, 1'b0};
    vt[9]  = '{"set_wr_r9",  2'b01, 5'd9,  32'h1234,     5'd0,  32'd0,  1'b1, 5'd9, 5'd9,  5'd5,  32'h1234,     32'hDEADBEEF, 1'b1, 1'b0};
    vt[10] = '{"rd_r9",      2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b0, 5'd0, 5'd9,  5'd9,  32'h1234,     32'h1234,     1'b1, 1'b1};
    vt[11] = '{"bset_r0",    2'b00, 5'd0,  32'd0,        5'd0,  32'd0,  1'b1, 5'd0, 5'd0,  5'd9,  32'd0,        32'h1234,     1'b0, 1'b1};
    vt[12] = '{"dual_byp",   2'b11, 5'd12, 32'hA,        5'd13, 32'hB,  1'b0, 5'd0, 5'd13, 5'd12, 32'hB,        32'hA,        1'b0, 1'b0};

    do_reset(3);

    for (int k = 0; k < 13; k++) begin
      set_in(vt[k].we, vt[k].wa0, vt[k].wd0, vt[k].wa1, vt[k].wd1, vt[k].bs, vt[k].ba,
             vt[k].ra0, vt[k].ra1);
      step(vt[k].name, vt[k].d0, vt[k].d1, vt[k].b0, vt[k].b1);
    end

    // Fill r1..r31: port 1 sees the bypassed new value, port 0 the stored previous one.
    for (int a = 1; a < 32; a++) begin
      set_in(2'b01, 5'(a), val(a), 5'd0, 32'd0, 1'b0, 5'd0, 5'(a - 1), 5'(a));
      step($sformatf("fill_r%0d", a), (a == 1) ? 32'd0 : val(a - 1), val(a), 1'b0, 1'b0);
    end
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd9);
    step("bset_r3", val(3), val(9), 1'b1, 1'b0);
    set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd31);
    step("rd_r3_r31", val(3), val(31), 1'b1, 1'b0);

    do_reset(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
